// File: rtl/mode1_max.sv
// Row-maximum reducer for FP16 attention scores: four lanes per beat, a
// two-stage compare pipeline, and a sticky NaN flag that overrides the result.
module mode1_max #(
  parameter int DATAWIDTH = 16,
  parameter int CNTW      = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [CNTW-1:0]      num_beats,
  input  logic                 in_valid,
  input  logic [DATAWIDTH-1:0] inp0,
  input  logic [DATAWIDTH-1:0] inp1,
  input  logic [DATAWIDTH-1:0] inp2,
  input  logic [DATAWIDTH-1:0] inp3,
  output logic                 in_ready,
  output logic                 busy,
  output logic [DATAWIDTH-1:0] max_out,
  output logic                 max_valid
);

  localparam int EXPW = 5;
  localparam int MANW = DATAWIDTH - 1 - EXPW;

  localparam logic [DATAWIDTH-1:0] NEG_INF   = 16'hFC00;
  localparam logic [DATAWIDTH-1:0] QNAN      = 16'h7E00;
  localparam logic [DATAWIDTH-1:0] ZERO_VAL  = 16'h0000;
  localparam logic [DATAWIDTH-1:0] SIGN_MASK = 16'h8000;
  localparam logic [CNTW-1:0]      CNT_ZERO  = {CNTW{1'b0}};
  localparam logic [CNTW-1:0]      CNT_ONE   = {{(CNTW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Monotonic key: negatives are bit-inverted, positives get the sign flipped,
  // so an unsigned compare of keys orders the floating-point values.
  function automatic logic [DATAWIDTH-1:0] order_key(input logic [DATAWIDTH-1:0] v);
    logic [DATAWIDTH-1:0] k;
    if (v[DATAWIDTH-1]) begin
      k = ~v;
    end else begin
      k = v ^ SIGN_MASK;
    end
    return k;
  endfunction

  function automatic logic is_nan(input logic [DATAWIDTH-1:0] v);
    return (&v[DATAWIDTH-2:MANW]) && (|v[MANW-1:0]);
  endfunction

  // Strict greater-than so that ties keep the incumbent operand a.
  function automatic logic [DATAWIDTH-1:0] fp_max(input logic [DATAWIDTH-1:0] a,
                                                  input logic [DATAWIDTH-1:0] b);
    logic [DATAWIDTH-1:0] m;
    if (order_key(b) > order_key(a)) begin
      m = b;
    end else begin
      m = a;
    end
    return m;
  endfunction

  state_t               state_r;
  logic [CNTW-1:0]      cnt_r;
  logic [DATAWIDTH-1:0] acc_r;
  logic                 nan_r;
  logic [DATAWIDTH-1:0] lane_max_r;
  logic                 lane_vld_r;
  logic                 in_ready_r;
  logic                 busy_r;
  logic [DATAWIDTH-1:0] max_out_r;
  logic                 max_valid_r;

  logic                 accept_s;
  logic                 start_ok_s;
  logic [DATAWIDTH-1:0] beat_max_s;
  logic                 beat_nan_s;
  logic [DATAWIDTH-1:0] acc_next_s;

  // Beat acceptance, per-beat lane reduction and accumulator lookahead.
  always_comb begin
    accept_s   = in_valid && in_ready_r;
    start_ok_s = (state_r == IDLE) && start && (num_beats != CNT_ZERO);
    beat_max_s = fp_max(fp_max(inp0, inp1), fp_max(inp2, inp3));
    beat_nan_s = is_nan(inp0) || is_nan(inp1) || is_nan(inp2) || is_nan(inp3);
    if (lane_vld_r) begin
      acc_next_s = fp_max(acc_r, lane_max_r);
    end else begin
      acc_next_s = acc_r;
    end
  end

  // Datapath: lane-max stage, running accumulator and sticky NaN flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      lane_max_r <= ZERO_VAL;
      lane_vld_r <= 1'b0;
      acc_r      <= NEG_INF;
      nan_r      <= 1'b0;
    end else begin
      lane_vld_r <= accept_s;
      if (accept_s) begin
        lane_max_r <= beat_max_s;
      end
      if (start_ok_s) begin
        acc_r <= NEG_INF;
        nan_r <= 1'b0;
      end else begin
        acc_r <= acc_next_s;
        if (accept_s && beat_nan_s) begin
          nan_r <= 1'b1;
        end
      end
    end
  end

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      cnt_r       <= CNT_ZERO;
      in_ready_r  <= 1'b0;
      busy_r      <= 1'b0;
      max_out_r   <= ZERO_VAL;
      max_valid_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          max_valid_r <= 1'b0;
          if (start_ok_s) begin
            cnt_r      <= num_beats;
            state_r    <= RUN;
            in_ready_r <= 1'b1;
            busy_r     <= 1'b1;
          end
        end
        RUN: begin
          if (accept_s) begin
            cnt_r <= cnt_r - CNT_ONE;
            if (cnt_r == CNT_ONE) begin
              state_r    <= DRAIN;
              in_ready_r <= 1'b0;
            end
          end
        end
        DRAIN: begin
          // The final lane_max lands in the accumulator on this same edge.
          state_r     <= DONE;
          max_out_r   <= nan_r ? QNAN : acc_next_s;
          max_valid_r <= 1'b1;
        end
        DONE: begin
          state_r     <= IDLE;
          busy_r      <= 1'b0;
          max_valid_r <= 1'b0;
        end
        default: begin
          state_r     <= IDLE;
          in_ready_r  <= 1'b0;
          busy_r      <= 1'b0;
          max_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign busy      = busy_r;
  assign max_out   = max_out_r;
  assign max_valid = max_valid_r;

endmodule

// File: tb/tb_mode1_max.sv
// Directed bench for mode1_max: hand-computed row maxima, latency,
// NaN/Inf handling, stalls, ignored controls and reset abort.
module tb_mode1_max;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [5:0]  num_beats;
  logic        in_valid;
  logic [15:0] inp0, inp1, inp2, inp3;
  logic        in_ready;
  logic        busy;
  logic [15:0] max_out;
  logic        max_valid;

  int n_checks = 0;
  int n_errors = 0;
  logic [15:0] beats [0:63][0:3];

  mode1_max #(.DATAWIDTH(16), .CNTW(6)) dut (
    .clk(clk), .reset(reset), .start(start), .num_beats(num_beats),
    .in_valid(in_valid), .inp0(inp0), .inp1(inp1), .inp2(inp2), .inp3(inp3),
    .in_ready(in_ready), .busy(busy), .max_out(max_out), .max_valid(max_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_beat(input int b, input logic [15:0] a0, input logic [15:0] a1,
                          input logic [15:0] a2, input logic [15:0] a3);
    beats[b][0] = a0; beats[b][1] = a1; beats[b][2] = a2; beats[b][3] = a3;
  endtask

  // Runs one row from the first IDLE cycle and checks latency and result.
  task automatic run_row(input string tag, input int nb, input bit gaps, input logic [15:0] exp);
    int pulses;
    if (gaps) begin
      in_valid = 1'b1;
      inp0 = 16'h7BFF; inp1 = 16'h7BFF; inp2 = 16'h7BFF; inp3 = 16'h7BFF;
      step();
      in_valid = 1'b0;
      check({tag, "_idle_busy"}, {15'd0, busy}, 16'd0);
    end
    start = 1'b1;
    num_beats = nb[5:0];
    step();
    start = 1'b0;
    check({tag, "_run_busy"}, {15'd0, busy}, 16'd1);
    check({tag, "_run_ready"}, {15'd0, in_ready}, 16'd1);
    for (int b = 0; b < nb; b++) begin
      if (gaps && b > 0) begin
        in_valid = 1'b0;
        start = 1'b1;
        num_beats = 6'd5;
        inp0 = 16'h7BFF; inp1 = 16'h7BFF; inp2 = 16'h7BFF; inp3 = 16'h7BFF;
        step();
        start = 1'b0;
      end
      in_valid = 1'b1;
      inp0 = beats[b][0]; inp1 = beats[b][1]; inp2 = beats[b][2]; inp3 = beats[b][3];
      step();
    end
    in_valid = 1'b0;
    check({tag, "_t1_ready"}, {15'd0, in_ready}, 16'd0);
    check({tag, "_t1_valid"}, {15'd0, max_valid}, 16'd0);
    step();
    check({tag, "_t2_valid"}, {15'd0, max_valid}, 16'd1);
    check({tag, "_max"}, max_out, exp);
    pulses = 0;
    step();
    if (max_valid) pulses++;
    check({tag, "_idle_busy_end"}, {15'd0, busy}, 16'd0);
    check({tag, "_single_pulse"}, pulses[15:0], 16'd0);
  endtask

  initial begin
    int pulses;
    reset = 1'b1; start = 1'b0; num_beats = 6'd0; in_valid = 1'b0;
    inp0 = 16'h0000; inp1 = 16'h0000; inp2 = 16'h0000; inp3 = 16'h0000;
    step();
    step();
    reset = 1'b0;
    check("rst_ready", {15'd0, in_ready}, 16'd0);
    check("rst_busy", {15'd0, busy}, 16'd0);
    check("rst_max", max_out, 16'h0000);
    check("rst_valid", {15'd0, max_valid}, 16'd0);

    set_beat(0, 16'h3C00, 16'hBC00, 16'h3800, 16'hC000);
    set_beat(1, 16'h4000, 16'h0000, 16'h3C00, 16'h3800);
    run_row("single", 2, 1'b0, 16'h4000);

    set_beat(0, 16'hBC00, 16'h8000, 16'hC000, 16'hFC00);
    run_row("negzero", 1, 1'b0, 16'h8000);

    set_beat(0, 16'h7C00, 16'h0000, 16'h0000, 16'h0000);
    set_beat(1, 16'h7E01, 16'h0000, 16'h0000, 16'h0000);
    run_row("nan", 2, 1'b0, 16'h7E00);
    set_beat(1, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    run_row("inf", 2, 1'b0, 16'h7C00);

    set_beat(0, 16'h3C00, 16'h4200, 16'hBC00, 16'h0000);
    set_beat(1, 16'h4800, 16'h4600, 16'h0400, 16'h8000);
    set_beat(2, 16'h4A00, 16'hC400, 16'h3800, 16'h4000);
    run_row("gaps", 3, 1'b1, 16'h4A00);

    start = 1'b1; num_beats = 6'd0;
    step();
    start = 1'b0;
    check("nb0_busy", {15'd0, busy}, 16'd0);
    check("nb0_hold", max_out, 16'h4A00);

    start = 1'b1; num_beats = 6'd4;
    step();
    start = 1'b0;
    in_valid = 1'b1;
    inp0 = 16'h5000; inp1 = 16'h0000; inp2 = 16'h0000; inp3 = 16'h0000;
    step();
    reset = 1'b1; start = 1'b1;
    step();
    reset = 1'b0; start = 1'b0; in_valid = 1'b0;
    check("abort_busy", {15'd0, busy}, 16'd0);
    check("abort_max", max_out, 16'h0000);
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      if (max_valid) pulses++;
      step();
    end
    check("abort_no_pulse", pulses[15:0], 16'd0);
    check("abort_still_idle", {15'd0, busy}, 16'd0);

    set_beat(0, 16'h7C00, 16'h0000, 16'h0000, 16'h0000);
    run_row("b2b_a", 1, 1'b0, 16'h7C00);
    set_beat(0, 16'hC000, 16'hC200, 16'hC400, 16'hC800);
    run_row("b2b_b", 1, 1'b0, 16'hC000);

    for (int b = 0; b < 63; b++) begin
      set_beat(b, 16'h3000 + 16'(b), 16'hB000 + 16'(b), 16'h2000 + 16'(b), 16'h3400 + 16'(b));
    end
    beats[62][3] = 16'h7000;
    run_row("full63", 63, 1'b0, 16'h7000);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mode1_max.md
MODE1_MAX -- requirements
Module: mode1_max

Interface
REQ-001 Parameter: DATAWIDTH, default 16, IEEE half-precision lane width (1 sign, 5 exponent, 10 mantissa).
REQ-002 Parameter: CNTW, default 6, width of the beat counter (max 63 beats per row).
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  begin a new row-max operation (sampled in IDLE only).
REQ-006 num_beats  input  CNTW  beats in the row (4 elements per beat); sampled with start.
REQ-007 in_valid  input  1  inp0..inp3 carry a valid beat.
REQ-008 inp0, inp1, inp2, inp3  input  DATAWIDTH each  FP16 score elements of one beat.
REQ-009 in_ready  output  1  high exactly while state is RUN; a beat is accepted when in_valid and in_ready are both high.
REQ-010 busy  output  1  high in any state other than IDLE.
REQ-011 max_out  output  DATAWIDTH  FP16 row maximum; feeds the subtract stage ahead of the exp stage.
REQ-012 max_valid  output  1  one-cycle pulse; max_out is final while it is high.

Function
REQ-013 FSM states: IDLE, RUN, DRAIN, DONE.
REQ-014 IDLE: start=1 with num_beats!=0 -> load counter with num_beats, set accumulator to 0xFC00 (-Inf), clear NaN flag, go to RUN.
REQ-015 IDLE: start=1 with num_beats==0 is ignored; the FSM stays in IDLE.
REQ-016 RUN: each accepted beat decrements the counter; the beat accepted with counter==1 moves the FSM to DRAIN.
REQ-017 DRAIN lasts exactly one cycle and then goes to DONE; DONE lasts exactly one cycle and then goes to IDLE.
REQ-018 in_valid outside RUN is ignored; start outside IDLE is ignored.
REQ-019 Ordering key for non-NaN values: if sign=1, key = bitwise NOT of the value; else key = value XOR 0x8000; compare keys unsigned.
REQ-020 Consequences of REQ-019: +0 (0x0000) > -0 (0x8000); +Inf > all finite values; -Inf < all finite values.
REQ-021 Ties on equal keys keep the existing value (lowest lane index within a beat, earlier beat across beats).
REQ-022 NaN is exponent==31 with mantissa!=0; any NaN lane in an accepted beat sets a sticky NaN flag for the row.
REQ-023 Pipeline stage 1: on acceptance, the max of the 4 lanes is registered (lane_max, lane_vld) in the following cycle.
REQ-024 Pipeline stage 2: lane_vld=1 updates the accumulator to max(accumulator, lane_max) at that clock edge.
REQ-025 Latency: last beat accepted in cycle t -> max_valid=1 in cycle t+2.
REQ-026 Back-to-back beats (in_valid held high) are accepted every cycle with no bubbles; gaps in in_valid are allowed.
REQ-027 In DONE: max_out = 0x7E00 if the NaN flag is set, else the accumulator; max_valid=1.
REQ-028 max_out holds its value after DONE until the next accepted start.
REQ-029 A new start may be issued in the cycle after DONE (first IDLE cycle).

Reset
REQ-030 reset=1 at a clock edge forces IDLE, counter=0, accumulator=0xFC00, NaN flag=0, lane_vld=0, max_out=0x0000, max_valid=0.
REQ-031 Consequently in_ready=0 and busy=0 after reset.
REQ-032 reset mid-operation (RUN, DRAIN or DONE) aborts the row without a max_valid pulse; reset has priority over start and in_valid.

Verification
REQ-033 Single row: num_beats=2; beats {0x3C00,0xBC00,0x3800,0xC000}, {0x4000,0x0000,0x3C00,0x3800} -> max_valid 2 cycles after the 2nd beat, max_out=0x4000.
REQ-034 All-negative row with -0: num_beats=1; beat {0xBC00,0x8000,0xC000,0xFC00} -> max_out=0x8000.
REQ-035 NaN and Inf: num_beats=2; beat1 {0x7C00,0,0,0}, beat2 {0x7E01,0,0,0} -> max_out=0x7E00; repeat without the NaN -> max_out=0x7C00.
REQ-036 Stalls and ignored inputs: num_beats=3 with in_valid gaps, a start pulse during RUN, and in_valid asserted in IDLE -> exactly 3 beats counted; max_out equals the true max; one max_valid pulse.
REQ-037 Control corners: start with num_beats=0 -> busy stays 0; reset in RUN after 1 of 4 beats -> no max_valid, max_out=0x0000; a new row started the cycle after DONE -> its result is not affected by the previous row.
REQ-038 Full length: num_beats=63 with 63 consecutive valid beats, maximum in the final beat, lane 3 -> that value is reported, and max_valid rises in cycle t+2 of the final beat.
